// File: rtl/aes_pkg.sv
// Types and constants shared by the AES cipher, key-expansion and round-control blocks.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_HOLD  = 3'd4
  } aes_state_t;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  localparam logic [7:0] KEY_LEN_128 = 8'd16;
  localparam logic [7:0] KEY_LEN_192 = 8'd24;
  localparam logic [7:0] KEY_LEN_256 = 8'd32;

  // Zero marks an unsupported key length.
  function automatic logic [3:0] nr_for_key_len(input logic [7:0] key_len);
    case (key_len)
      KEY_LEN_128: return NR_128;
      KEY_LEN_192: return NR_192;
      KEY_LEN_256: return NR_256;
      default:     return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES datapath: load, NR rounds, hold result until consumed.
//
// state    | meaning
// IDLE     | waiting for start, ready=1
// LOAD     | load block, apply round key 0 (enc) or NR (dec)
// ROUND    | full rounds, counter walks NR-1 down to 1
// FINAL    | last round without (Inv)MixColumns
// HOLD     | result valid until out_ready
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int MAX_NR = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] key_len,
  input  logic       abort,
  input  logic       out_ready,
  output logic       ready,
  output logic       busy,
  output logic       ld_state,
  output logic       rnd_en,
  output logic       final_rnd,
  output logic [3:0] round_idx,
  output logic [3:0] nr,
  output logic       out_valid,
  output logic       err
);

  aes_state_t state, state_nxt;
  logic [3:0] cnt;
  logic [3:0] nr_q;
  logic       mode_q;
  logic       err_q;

  logic [3:0] nr_req;
  logic       key_ok;
  logic       start_idle;
  logic       accept;
  logic       reject;

  assign nr_req     = nr_for_key_len(key_len);
  assign key_ok     = (nr_req != 4'd0) && (int'(nr_req) <= MAX_NR);
  assign start_idle = (state == ST_IDLE) && start && !abort;
  assign accept     = start_idle && key_ok;
  assign reject     = start_idle && !key_ok;

  // cnt is a down-counter loaded with NR; it reaches 0 exactly in FINAL,
  // so encrypt indexes as NR-cnt and decrypt indexes as cnt directly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      nr_q   <= 4'd0;
      mode_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= reject;
      if (accept) begin
        nr_q   <= nr_req;
        mode_q <= mode;
        cnt    <= nr_req;
      end else if (state == ST_LOAD || state == ST_ROUND) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = abort ? ST_IDLE : ST_ROUND;
      ST_ROUND: begin
        if (abort)              state_nxt = ST_IDLE;
        else if (cnt == 4'd1)   state_nxt = ST_FINAL;
      end
      ST_FINAL: state_nxt = abort ? ST_IDLE : ST_HOLD;
      ST_HOLD:  if (abort || out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    ld_state  = (state == ST_LOAD);
    rnd_en    = (state == ST_ROUND) || (state == ST_FINAL);
    final_rnd = (state == ST_FINAL);
    out_valid = (state == ST_HOLD);
    nr        = nr_q;
    err       = err_q;
    round_idx = 4'd0;
    if (state == ST_LOAD || state == ST_ROUND || state == ST_FINAL)
      round_idx = mode_q ? cnt : (nr_q - cnt);
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: stimulus pushes the expected event trace, a monitor pops and compares.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, mode, abort, out_ready;
  logic [7:0] key_len;
  logic       ready, busy, ld_state, rnd_en, final_rnd, out_valid, err;
  logic [3:0] round_idx, nr_o;

  aes_round_ctrl #(.MAX_NR(14)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .key_len(key_len),
    .abort(abort), .out_ready(out_ready), .ready(ready), .busy(busy),
    .ld_state(ld_state), .rnd_en(rnd_en), .final_rnd(final_rnd),
    .round_idx(round_idx), .nr(nr_o), .out_valid(out_valid), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       ld, rnd, fin;
    logic [3:0] idx;
    logic       ov, er, rdy, bsy;
    logic [3:0] nr;
  } ev_t;

  ev_t        expq[$];
  int         compared = 0;
  int         mismatched = 0;
  logic [3:0] last_nr = 4'd0;
  bit         mon_en = 1'b0;

  function automatic int nr_of(input logic [7:0] kl);
    if (kl == 8'd16 || kl == 8'd24 || kl == 8'd32) return int'(kl) / 4 + 6;
    return 0;
  endfunction

  function automatic logic [7:0] rand_kl();
    case ($urandom_range(0, 3))
      0: return 8'd16;
      1: return 8'd24;
      2: return 8'd32;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic ld, rnd, fin, input logic [3:0] idx,
                         input logic ov, er, rdy, bsy, input logic [3:0] n);
    ev_t e;
    e.cyc = c; e.ld = ld; e.rnd = rnd; e.fin = fin; e.idx = idx;
    e.ov = ov; e.er = er; e.rdy = rdy; e.bsy = bsy; e.nr = n;
    expq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for spec cycle rel (1 = cycle after acceptance edge).
  task automatic push_op_cycle(input int base, input int rel, input logic m, input int n);
    int r;
    if (rel == 1)
      push_ev(base + rel, 1, 0, 0, m ? 4'(n) : 4'd0, 0, 0, 0, 1, 4'(n));
    else if (rel <= n + 1) begin
      r = rel - 1;
      push_ev(base + rel, 0, 1, r == n, m ? 4'(n - r) : 4'(r), 0, 0, 0, 1, 4'(n));
    end else
      push_ev(base + rel, 0, 0, 0, 4'd0, 1, 0, 0, 1, 4'(n));
  endtask

  // w: HOLD cycles with out_ready=0 before release; abort_at: spec cycle of abort (0 = none).
  task automatic run_op(input logic m, input logic [7:0] kl, input int w, input int abort_at);
    int n, base, hold, last;
    n    = nr_of(kl);
    base = cyc;
    hold = n + 2;
    last = (abort_at > 0) ? abort_at : hold + w;
    mode = m; key_len = kl; start = 1'b1; abort = 1'b0;
    out_ready = 1'($urandom_range(0, 1));
    for (int rel = 1; rel <= last; rel++) push_op_cycle(base, rel, m, n);
    last_nr = 4'(n);
    for (int rel = 1; rel <= last; rel++) begin
      tick();
      start   = 1'($urandom_range(0, 1));
      mode    = 1'($urandom_range(0, 1));
      key_len = rand_kl();
      abort   = (rel == abort_at);
      if (rel < hold) out_ready = 1'($urandom_range(0, 1));
      else            out_ready = (rel >= hold + w);
    end
    tick();
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    check("ready_after_op", ready, 1);
    check("busy_after_op", busy, 0);
    check("nr_latched", nr_o, 32'(n));
  endtask

  task automatic run_err(input logic [7:0] kl);
    int base;
    base = cyc;
    mode = 1'($urandom_range(0, 1)); key_len = kl; start = 1'b1; abort = 1'b0;
    push_ev(base + 1, 0, 0, 0, 4'd0, 0, 1, 1, 0, last_nr);
    tick();
    start = 1'b0;
    check("ready_on_err", ready, 1);
    check("busy_on_err", busy, 0);
    tick();
    check("err_single_cycle", err, 0);
  endtask

  task automatic run_abort_start();
    key_len = 8'd16; mode = 1'b0; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_start_ready", ready, 1);
    check("abort_start_err", err, 0);
    tick();
    check("abort_start_idle", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ctl"}, {ld_state, rnd_en, final_rnd, out_valid, err}, 0);
    check({tag, "_idx"}, round_idx, 0);
    check({tag, "_nr"}, nr_o, 0);
  endtask

  task automatic run_reset(input logic m, input logic [7:0] kl, input int rst_at);
    int n, base;
    n = nr_of(kl);
    base = cyc;
    mode = m; key_len = kl; start = 1'b1; abort = 1'b0; out_ready = 1'b0;
    for (int rel = 1; rel <= rst_at; rel++) push_op_cycle(base, rel, m, n);
    for (int rel = 1; rel <= rst_at; rel++) begin
      tick();
      start = 1'b0;
      if (rel == rst_at) begin
        reset = 1'b0; start = 1'b1; key_len = 8'd16;
      end
    end
    tick();
    last_nr = 4'd0;
    check_reset_outputs("midop_reset");
    tick();
    check_reset_outputs("start_in_reset");
    reset = 1'b1; start = 1'b0;
    tick();
    check_reset_outputs("after_release");
  endtask

  initial begin
    ev_t e, m;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
          m = expq.pop_front();
          compared++; mismatched++;
          $display("FAIL missing_event: expected at cyc %0d, nothing seen", m.cyc);
        end
        if (ld_state || rnd_en || final_rnd || out_valid || err || round_idx != 4'd0) begin
          if (expq.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_event: cyc %0d ld=%b rnd=%b fin=%b idx=%0d ov=%b err=%b",
                     cyc, ld_state, rnd_en, final_rnd, round_idx, out_valid, err);
          end else begin
            e = expq.pop_front();
            compared++;
            if (e.cyc != cyc || ld_state !== e.ld || rnd_en !== e.rnd || final_rnd !== e.fin ||
                round_idx !== e.idx || out_valid !== e.ov || err !== e.er ||
                ready !== e.rdy || busy !== e.bsy || nr_o !== e.nr) begin
              mismatched++;
              $display("FAIL event: got cyc=%0d ld=%b rnd=%b fin=%b idx=%0d ov=%b err=%b rdy=%b bsy=%b nr=%0d want cyc=%0d ld=%b rnd=%b fin=%b idx=%0d ov=%b err=%b rdy=%b bsy=%b nr=%0d",
                       cyc, ld_state, rnd_en, final_rnd, round_idx, out_valid, err, ready, busy, nr_o,
                       e.cyc, e.ld, e.rnd, e.fin, e.idx, e.ov, e.er, e.rdy, e.bsy, e.nr);
            end
          end
        end
      end
    end
  end

  initial begin
    int n, w, ab;
    logic [7:0] kl;
    reset = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; out_ready = 1'b0; key_len = 8'd0;
    tick();
    tick();
    check_reset_outputs("por");
    mon_en = 1'b1;
    reset = 1'b1;
    tick();

    run_op(1'b0, 8'd16, 0, 0);
    run_op(1'b1, 8'd32, 0, 0);
    run_err(8'd20);
    run_op(1'b0, 8'd24, 5, 0);
    run_op(1'b0, 8'd16, 0, 4);
    run_op(1'b0, 8'd16, 0, 0);
    run_reset(1'b1, 8'd32, 6);
    run_op(1'b1, 8'd24, 2, 12 + 2 + 2);
    run_op(1'b0, 8'd32, 3, 14 + 2 + 1);
    run_abort_start();
    run_op(1'b1, 8'd16, 0, 1);

    for (int i = 0; i < 25; i++) begin
      kl = rand_kl();
      n = nr_of(kl);
      if (n == 0) run_err(kl);
      else begin
        w  = $urandom_range(0, 4);
        ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n + 2 + w) : 0;
        run_op(1'($urandom_range(0, 1)), kl, w, ab);
      end
    end

    tick();
    tick();
    check("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
